// File: rtl/draw_back_fx.sv
// Background/overlay layer: playfield border plus INIT/DEAD/WIN message band.
// Mode latches only at frame start, so a request change never tears a frame.
module draw_back_fx #(
    parameter int unsigned LEFT         = 160,
    parameter int unsigned TOP          = 40,
    parameter int unsigned MAXX         = 640,
    parameter int unsigned MAXY         = 480,
    parameter int unsigned MSG_H        = 320,
    parameter int unsigned BORDER_W     = 72,
    parameter int unsigned CELL_LOG2    = 4,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned COLOR_W      = 4,
    parameter logic [COLOR_W-1:0] C_INIT   = 4'hE,
    parameter logic [COLOR_W-1:0] C_DEAD   = 4'hB,
    parameter logic [COLOR_W-1:0] C_WIN    = 4'hD,
    parameter logic [COLOR_W-1:0] C_BORDER = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        vcounter,
    input  logic [11:0]        hcounter,
    input  logic               dead,
    input  logic               init,
    input  logic               win,
    output logic [4:0]         glyph_row,
    output logic [4:0]         glyph_col,
    output logic [1:0]         glyph_sel,
    input  logic               glyph_bit,
    output logic [COLOR_W-1:0] out,
    output logic [1:0]         mode
);

    localparam logic [1:0] MODE_INIT = 2'b00;
    localparam logic [1:0] MODE_DEAD = 2'b01;
    localparam logic [1:0] MODE_IDLE = 2'b10;
    localparam logic [1:0] MODE_WIN  = 2'b11;

    localparam int unsigned FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

    // All region arithmetic is done at 13 bits so sums never wrap.
    localparam logic [12:0] TOP13     = 13'(TOP);
    localparam logic [12:0] LEFT13    = 13'(LEFT);
    localparam logic [12:0] BW13      = 13'(BORDER_W);
    localparam logic [12:0] MSG_END   = 13'(TOP + MSG_H);
    localparam logic [12:0] RIGHT13   = 13'(LEFT + MAXX);
    localparam logic [12:0] RIGHT_END = 13'(LEFT + MAXX + BORDER_W);
    localparam logic [12:0] BOT13     = 13'(TOP + MAXY);
    localparam logic [12:0] BOT_END   = 13'(TOP + MAXY + BORDER_W);

    logic [1:0]         mode_q, mode_d, req_mode;
    logic [FCW-1:0]     frame_q, frame_d;
    logic               blink_q, blink_d;
    logic [1:0]         pal_q, pal_d;
    logic [COLOR_W-1:0] out_q, out_d;
    logic [COLOR_W-1:0] pal_mask;
    logic [12:0]        v13, h13, vrel, hrel;
    logic               fs, in_msg, in_border;

    assign v13  = {2'b00, vcounter};
    assign h13  = {1'b0, hcounter};
    assign vrel = v13 - TOP13;
    assign hrel = h13 - LEFT13;
    assign fs   = (vcounter == 11'd0) && (hcounter == 12'd0);

    assign glyph_row = vrel[CELL_LOG2 +: 5];
    assign glyph_col = hrel[CELL_LOG2 +: 5];
    assign glyph_sel = mode_q;
    assign mode      = mode_q;
    assign out       = out_q;

    always_comb begin
        req_mode = MODE_IDLE;
        if (dead) begin
            req_mode = MODE_DEAD;
        end else if (init) begin
            req_mode = MODE_INIT;
        end else if (win) begin
            req_mode = MODE_WIN;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        frame_d = frame_q;
        blink_d = blink_q;
        pal_d   = pal_q;
        if (fs) begin
            if (req_mode != mode_q) begin
                mode_d  = req_mode;
                frame_d = '0;
                blink_d = 1'b1;
                pal_d   = 2'd0;
            end else if (frame_q == FC_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
                pal_d   = pal_q + 2'd1;
            end else begin
                frame_d = frame_q + FCW'(1);
            end
        end
    end

    always_comb begin
        in_msg = (v13 >= TOP13) && (v13 < MSG_END) && (h13 >= LEFT13) && (h13 < RIGHT13);
        in_border = !in_msg &&
                    (((v13 >= BOT13) && (v13 < BOT_END)) ||
                     ((v13 < TOP13) && ((v13 + BW13) >= TOP13)) ||
                     ((h13 >= RIGHT13) && (h13 < RIGHT_END)) ||
                     ((h13 < LEFT13) && ((h13 + BW13) >= LEFT13)));
    end

    // Palette mask is {pal, pal} repeated across the colour width.
    always_comb begin
        pal_mask = '0;
        for (int i = 0; i < int'(COLOR_W); i++) begin
            pal_mask[i] = pal_q[i[0]];
        end
    end

    always_comb begin
        out_d = '0;
        if (in_msg) begin
            case (mode_q)
                MODE_INIT: out_d = glyph_bit ? C_INIT : '0;
                MODE_DEAD: out_d = (glyph_bit && blink_q) ? C_DEAD : '0;
                MODE_WIN:  out_d = glyph_bit ? C_WIN : '0;
                default:   out_d = '0;
            endcase
        end else if (in_border) begin
            out_d = (mode_q == MODE_WIN) ? (C_BORDER ^ pal_mask) : C_BORDER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_IDLE;
            frame_q <= '0;
            blink_q <= 1'b1;
            pal_q   <= 2'd0;
            out_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            pal_q   <= pal_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_draw_back_fx.sv
// Bench for draw_back_fx: three instances share stimulus (BLINK_FRAMES 30, 2, 1).
// Expected colours are queued when a pixel is driven and popped after its clock edge.
module tb_draw_back_fx;

    localparam int LEFT = 160;
    localparam int TOP  = 40;
    localparam int MAXX = 640;
    localparam int MAXY = 480;
    localparam int BW   = 72;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vcounter;
    logic [11:0] hcounter;
    logic        dead, init, win, glyph_bit;

    logic [4:0] row_a, col_a, row_b, col_b, row_c, col_c;
    logic [1:0] sel_a, sel_b, sel_c, mode_a, mode_b, mode_c;
    logic [3:0] out_a, out_b, out_c;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    logic [3:0] e;

    always #5 clk = ~clk;

    draw_back_fx dut_a (
        .clk(clk), .rst(rst), .vcounter(vcounter), .hcounter(hcounter),
        .dead(dead), .init(init), .win(win),
        .glyph_row(row_a), .glyph_col(col_a), .glyph_sel(sel_a),
        .glyph_bit(glyph_bit), .out(out_a), .mode(mode_a)
    );

    draw_back_fx #(.BLINK_FRAMES(2)) dut_b (
        .clk(clk), .rst(rst), .vcounter(vcounter), .hcounter(hcounter),
        .dead(dead), .init(init), .win(win),
        .glyph_row(row_b), .glyph_col(col_b), .glyph_sel(sel_b),
        .glyph_bit(glyph_bit), .out(out_b), .mode(mode_b)
    );

    draw_back_fx #(.BLINK_FRAMES(1)) dut_c (
        .clk(clk), .rst(rst), .vcounter(vcounter), .hcounter(hcounter),
        .dead(dead), .init(init), .win(win),
        .glyph_row(row_c), .glyph_col(col_c), .glyph_sel(sel_c),
        .glyph_bit(glyph_bit), .out(out_c), .mode(mode_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int v, input int h, input logic gb);
        vcounter  = 11'(v);
        hcounter  = 12'(h);
        glyph_bit = gb;
    endtask

    task automatic frame_start();
        set_px(0, 0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        dead = 1'b0;
        init = 1'b0;
        win  = 1'b0;
        set_px(TOP + 10, LEFT + 100, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        dead = 1'b1;
        init = 1'b0;
        win  = 1'b0;
        set_px(TOP + 10, LEFT + 100, 1'b1);
        tick();
        n_chk++;
        if (out_a !== 4'h0) begin
            n_fail++; $display("FAIL reset_out got %h want 0", out_a);
        end
        n_chk++;
        if (mode_a !== 2'b10 || sel_a !== 2'b10 || mode_b !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mode got %b/%b/%b want 10", mode_a, sel_a, mode_b);
        end
        rst  = 1'b0;
        dead = 1'b0;
        exp_q.push_back(4'hF);
        set_px(TOP + 400, LEFT + MAXX + 10, 1'b0);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e) begin
            n_fail++; $display("FAIL idle_border got %h want %h", out_a, e);
        end
        exp_q.push_back(4'h0);
        set_px(TOP + 10, LEFT + 100, 1'b1);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e) begin
            n_fail++; $display("FAIL idle_msg got %h want %h", out_a, e);
        end
    endtask

    task automatic test_init_sync();
        do_reset();
        init = 1'b1;
        set_px(200, 300, 1'b1);
        #1;
        n_chk++;
        if (row_a !== 5'd10 || col_a !== 5'd8) begin
            n_fail++; $display("FAIL glyph_addr got %0d,%0d want 10,8", row_a, col_a);
        end
        exp_q.push_back(4'h0);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e || mode_a !== 2'b10) begin
            n_fail++;
            $display("FAIL init_before_fs got %h/%b want %h/10", out_a, mode_a, e);
        end
        frame_start();
        init = 1'b0;
        exp_q.push_back(4'hE);
        set_px(200, 300, 1'b1);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e) begin
            n_fail++; $display("FAIL init_msg got %h want %h", out_a, e);
        end
        n_chk++;
        if (sel_a !== 2'b00 || mode_a !== 2'b00) begin
            n_fail++; $display("FAIL init_mode got %b/%b want 00", sel_a, mode_a);
        end
        exp_q.push_back(4'h0);
        set_px(200, 300, 1'b0);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e) begin
            n_fail++; $display("FAIL init_nobit got %h want %h", out_a, e);
        end
        frame_start();
        n_chk++;
        if (mode_a !== 2'b10) begin
            n_fail++; $display("FAIL init_release got %b want 10", mode_a);
        end
    endtask

    task automatic test_dead_blink();
        do_reset();
        dead = 1'b1;
        init = 1'b1;
        win  = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frame_start();
            n_chk++;
            if (mode_b !== 2'b01) begin
                n_fail++; $display("FAIL priority_mode f%0d got %b want 01", f, mode_b);
            end
            exp_q.push_back((((f / 2) % 2) == 0) ? 4'hB : 4'h0);
            set_px(TOP + 10, LEFT + 100, 1'b1);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (out_b !== e) begin
                n_fail++; $display("FAIL dead_blink f%0d got %h want %h", f, out_b, e);
            end
        end
    endtask

    task automatic test_win_palette();
        logic [3:0] pal_tbl [5];
        pal_tbl = '{4'hF, 4'hA, 4'h5, 4'h0, 4'hF};
        do_reset();
        win = 1'b1;
        for (int f = 0; f < 5; f++) begin
            frame_start();
            exp_q.push_back(pal_tbl[f]);
            set_px(TOP + 400, LEFT + MAXX + 10, 1'b0);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (out_c !== e) begin
                n_fail++; $display("FAIL win_border f%0d got %h want %h", f, out_c, e);
            end
            exp_q.push_back(4'hD);
            set_px(TOP + 10, LEFT + 100, 1'b1);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (out_c !== e || mode_c !== 2'b11) begin
                n_fail++;
                $display("FAIL win_msg f%0d got %h/%b want %h/11", f, out_c, mode_c, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int px [10][3];
        px = '{'{TOP + 400, LEFT - BW - 1, 0}, '{TOP + 400, LEFT - BW, 15},
               '{TOP + 400, LEFT + MAXX + BW - 1, 15}, '{TOP + 400, LEFT + MAXX + BW, 0},
               '{TOP + MAXY, LEFT + 100, 15}, '{TOP + MAXY + BW - 1, LEFT + 100, 15},
               '{TOP + MAXY + BW, LEFT + 100, 0}, '{TOP - 1, LEFT + 540, 15},
               '{TOP + 319, LEFT + 100, 0}, '{TOP + 320, LEFT + 100, 0}};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(4'(px[i][2]));
            set_px(px[i][0], px[i][1], 1'b1);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (out_a !== e) begin
                n_fail++;
                $display("FAIL boundary v%0d h%0d got %h want %h", px[i][0], px[i][1], out_a, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dead = 1'b1;
        frame_start();
        exp_q.push_back(4'hB);
        set_px(TOP + 10, LEFT + 100, 1'b1);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e || mode_a !== 2'b01) begin
            n_fail++; $display("FAIL dead_msg got %h/%b want %h/01", out_a, mode_a, e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (out_a !== 4'h0 || mode_a !== 2'b10) begin
            n_fail++; $display("FAIL midreset got %h/%b want 0/10", out_a, mode_a);
        end
        exp_q.push_back(4'h0);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e || mode_a !== 2'b10) begin
            n_fail++; $display("FAIL midreset_hold got %h/%b want %h/10", out_a, mode_a, e);
        end
        frame_start();
        exp_q.push_back(4'hB);
        set_px(TOP + 10, LEFT + 100, 1'b1);
        tick();
        e = exp_q.pop_front();
        n_chk++;
        if (out_a !== e || mode_a !== 2'b01) begin
            n_fail++; $display("FAIL relatch_dead got %h/%b want %h/01", out_a, mode_a, e);
        end
    endtask

    initial begin
        rst  = 1'b1;
        dead = 1'b0;
        init = 1'b0;
        win  = 1'b0;
        set_px(TOP + 10, LEFT + 100, 1'b0);
        tick();
        test_reset();
        test_init_sync();
        test_dead_blink();
        test_win_palette();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

endmodule
